// File: rtl/bus_rr_router_pkg.sv
// Shared types and constants for the round-robin bus router.
package bus_rr_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } rr_state_t;

    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] BCAST_DEFAULT = 8'hFF;

endpackage

// File: rtl/bus_rr_router_rr_sel.sv
// Combinational round-robin picker: first set request searching upward from ptr+1 with wrap.
module rr_sel #(
    parameter int drvrs = 4
) (
    input  logic [drvrs-1:0]         req,
    input  logic [$clog2(drvrs)-1:0] ptr,
    output logic [$clog2(drvrs)-1:0] idx,
    output logic                     valid
);
    localparam int IDXW = $clog2(drvrs);

    int j;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = drvrs; k >= 1; k--) begin
            j = (int'(ptr) + k) % drvrs;
            if (req[j]) begin
                idx   = IDXW'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_router.sv
// Round-robin bus router: pops one packet per grant from driver FIFOs and
// pushes it to the addressed receive FIFO(s), dropping invalid addresses.
module bus_rr_router
    import bus_rr_router_pkg::*;
#(
    parameter int                bits      = 1,
    parameter int                drvrs     = 4,
    parameter int                pckg_sz   = 16,
    parameter logic [ADDR_W-1:0] broadcast = BCAST_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic [$clog2(drvrs)-1:0]   grant_id,
    output logic                       busy,
    output logic                       drop_pls
);
    localparam int                IDXW    = $clog2(drvrs);
    localparam logic [drvrs-1:0]  ONE     = drvrs'(1);
    localparam logic [ADDR_W-1:0] DRV_CNT = ADDR_W'(drvrs);
    localparam logic [IDXW-1:0]   LAST    = IDXW'(drvrs - 1);

    if (bits != 1) begin : g_bits_unsupported
        $error("bus_rr_router: only a single bus (bits=1) is supported");
    end

    rr_state_t          state;
    logic [IDXW-1:0]    ptr;
    logic [pckg_sz-1:0] pkt;

    logic [IDXW-1:0]    sel_idx;
    logic               sel_valid;
    logic [drvrs-1:0]   sel_onehot;
    logic [pckg_sz-1:0] head_word;
    logic [ADDR_W-1:0]  dest;
    logic [drvrs-1:0]   dest_onehot;
    logic [drvrs-1:0]   bcast_mask;

    rr_sel #(.drvrs(drvrs)) u_rr_sel (
        .req   (pndng),
        .ptr   (ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_comb begin
        sel_onehot  = ONE << sel_idx;
        head_word   = D_pop[int'(grant_id)*pckg_sz +: pckg_sz];
        dest        = head_word[pckg_sz-1 -: ADDR_W];
        dest_onehot = ONE << dest;
        bcast_mask  = ~(ONE << grant_id);
    end

    // pkt only takes delivered words, so D_push holds its value across drops and idle cycles.
    assign D_push = {drvrs{pkt}};

    // Outputs are registered from the next-state decision: pop is visible in POP, push/drop in PUSH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= LAST;
            grant_id <= '0;
            pkt      <= '0;
            pop      <= '0;
            push     <= '0;
            drop_pls <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pop      <= '0;
            push     <= '0;
            drop_pls <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state    <= POP;
                        grant_id <= sel_idx;
                        ptr      <= sel_idx;
                        pop      <= sel_onehot;
                        busy     <= 1'b1;
                    end
                end
                POP: begin
                    if (pndng[grant_id]) begin
                        state <= PUSH;
                        busy  <= 1'b1;
                        if (dest == broadcast) begin
                            push <= bcast_mask;
                            pkt  <= head_word;
                        end else if (dest < DRV_CNT) begin
                            push <= dest_onehot;
                            pkt  <= head_word;
                        end else begin
                            drop_pls <= 1'b1;
                        end
                    end else begin
                        // Source emptied under us: abandon without dequeuing anything further.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                PUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_router.sv
// Self-checking bench for bus_rr_router: directed scenarios plus a randomized run
// against a transaction-level FIFO/arbitration model.
module tb_bus_rr_router;
    localparam int DRV = 4;
    localparam int PW  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DRV-1:0]    pndng = '0;
    logic [DRV*PW-1:0] D_pop = '0;
    logic [DRV-1:0]    pop, push;
    logic [DRV*PW-1:0] D_push;
    logic [1:0]        grant_id;
    logic              busy, drop_pls;

    int n_cmp = 0;
    int n_err = 0;

    bus_rr_router #(.bits(1), .drvrs(DRV), .pckg_sz(PW), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_pls (drop_pls)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        pndng = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({pop, push, drop_pls, busy, grant_id} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got pop=%b push=%b drop=%b busy=%b gid=%0d, expected all 0", pop, push, drop_pls, busy, grant_id);
        end
        n_cmp++;
        if (D_push !== '0) begin
            n_err++;
            $display("FAIL reset_dpush: got %h expected 0", D_push);
        end
        tick(); tick();
        n_cmp++;
        if ({pop, push, drop_pls, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got pop=%b push=%b drop=%b busy=%b, expected idle", pop, push, drop_pls, busy);
        end
    endtask

    task automatic test_unicast;
        pndng = 4'b0100;
        D_pop = {16'h0000, 16'h01AB, 16'h0000, 16'h0000};
        tick();
        n_cmp++;
        if (pop !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1 || push !== 4'b0000) begin
            n_err++;
            $display("FAIL uni_pop: got pop=%b gid=%0d busy=%b push=%b, expected pop=0100 gid=2 busy=1 push=0000", pop, grant_id, busy, push);
        end
        tick();
        pndng = '0;
        n_cmp++;
        if (push !== 4'b0010 || D_push !== {4{16'h01AB}} || pop !== 4'b0000 || drop_pls !== 1'b0) begin
            n_err++;
            $display("FAIL uni_push: got push=%b D_push=%h pop=%b drop=%b, expected push=0010 D_push=01AB x4", push, D_push, pop, drop_pls);
        end
        tick();
        n_cmp++;
        if (push !== 4'b0000 || busy !== 1'b0 || D_push !== {4{16'h01AB}}) begin
            n_err++;
            $display("FAIL uni_after: got push=%b busy=%b D_push=%h, expected 0000/0/held", push, busy, D_push);
        end
    endtask

    task automatic test_broadcast;
        pndng = 4'b0010;
        D_pop = {16'h0000, 16'h0000, 16'hFF55, 16'h0000};
        tick();
        n_cmp++;
        if (pop !== 4'b0010 || grant_id !== 2'd1) begin
            n_err++;
            $display("FAIL bc_pop: got pop=%b gid=%0d, expected 0010/1", pop, grant_id);
        end
        tick();
        pndng = '0;
        n_cmp++;
        if (push !== 4'b1101 || D_push !== {4{16'hFF55}} || drop_pls !== 1'b0) begin
            n_err++;
            $display("FAIL bc_push: got push=%b D_push=%h drop=%b, expected 1101 FF55 x4 0", push, D_push, drop_pls);
        end
        tick();
        n_cmp++;
        if (push !== 4'b0000) begin
            n_err++;
            $display("FAIL bc_once: got push=%b expected 0000", push);
        end
    endtask

    task automatic test_invalid;
        pndng = 4'b0001;
        D_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0733};
        tick();
        n_cmp++;
        if (pop !== 4'b0001 || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL inv_pop: got pop=%b gid=%0d, expected 0001/0", pop, grant_id);
        end
        tick();
        pndng = '0;
        n_cmp++;
        if (push !== 4'b0000 || drop_pls !== 1'b1 || D_push !== {4{16'hFF55}}) begin
            n_err++;
            $display("FAIL inv_drop: got push=%b drop=%b D_push=%h, expected 0000/1/FF55 held", push, drop_pls, D_push);
        end
        tick();
        n_cmp++;
        if (drop_pls !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL inv_idle: got drop=%b busy=%b, expected 0/0", drop_pls, busy);
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_pop;
        reset = 1'b1;
        tick();
        pndng = 4'b1111;
        D_pop = {16'h0012, 16'h0134, 16'h0256, 16'h0378};
        reset = 1'b0;
        for (int p = 0; p < 12; p++) begin
            tick();
            exp_pop = 4'b0001 << (p % 4);
            n_cmp++;
            if (pop !== exp_pop || grant_id !== 2'(p % 4)) begin
                n_err++;
                $display("FAIL fair_grant%0d: got pop=%b gid=%0d, expected pop=%b gid=%0d", p, pop, grant_id, exp_pop, p % 4);
            end
            tick();
            tick();
            n_cmp++;
            if (pop !== 4'b0000) begin
                n_err++;
                $display("FAIL fair_gap%0d: got pop=%b expected 0000", p, pop);
            end
        end
        pndng = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid;
        int extra;
        do_reset();
        pndng = 4'b1000;
        D_pop = {16'h0212, 16'h0000, 16'h0000, 16'h0000};
        tick();
        tick();
        n_cmp++;
        if (push !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_pre: got push=%b expected 0100", push);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (push !== 4'b0000 || busy !== 1'b0 || pop !== 4'b0000 || D_push !== '0) begin
            n_err++;
            $display("FAIL mid_async: got push=%b busy=%b pop=%b D_push=%h, expected all 0", push, busy, pop, D_push);
        end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (pop !== 4'b1000 || grant_id !== 2'd3) begin
            n_err++;
            $display("FAIL mid_regrant: got pop=%b gid=%0d, expected 1000/3", pop, grant_id);
        end
        tick();
        pndng = '0;
        n_cmp++;
        if (push !== 4'b0100 || D_push !== {4{16'h0212}}) begin
            n_err++;
            $display("FAIL mid_deliver: got push=%b D_push=%h, expected 0100 0212 x4", push, D_push);
        end
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (push !== 4'b0000) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL mid_once: got %0d extra push cycles, expected 0", extra);
        end
    endtask

    // Randomized run: driver FIFOs are queues; the model picks grants from queue occupancy.
    logic [PW-1:0] fifo [DRV][$];
    logic [3:0]    e_pop [4];
    logic [3:0]    e_push [4];
    logic          e_drop [4];
    logic          e_busy [4];
    logic          e_gset [4];
    logic [1:0]    e_grant [4];
    logic          e_dset [4];
    logic [PW-1:0] e_dval [4];

    function automatic logic [PW-1:0] rand_word();
        int r;
        logic [7:0] d;
        r = $urandom_range(0, 9);
        if (r < 6)      d = 8'($urandom_range(0, DRV - 1));
        else if (r < 8) d = 8'hFF;
        else            d = 8'($urandom_range(DRV, 254));
        return {d, 8'($urandom)};
    endfunction

    task automatic test_random;
        int         idle_at, m_last, g, s, s1, s2;
        logic [1:0] m_grant;
        logic [PW-1:0] m_dpush, w;
        logic [3:0] prev_pop, req;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            e_pop[i] = '0; e_push[i] = '0; e_drop[i] = 0; e_busy[i] = 0;
            e_gset[i] = 0; e_grant[i] = '0; e_dset[i] = 0; e_dval[i] = '0;
        end
        for (int i = 0; i < DRV; i++) fifo[i].delete();
        do_reset();
        idle_at = 0; m_last = DRV - 1; m_grant = '0; m_dpush = '0; prev_pop = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < DRV; i++)
                if (prev_pop[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
            if ($urandom_range(0, 2) == 0) fifo[$urandom_range(0, DRV - 1)].push_back(rand_word());
            for (int i = 0; i < DRV; i++) begin
                req[i] = fifo[i].size() > 0;
                D_pop[i*PW +: PW] = req[i] ? fifo[i][0] : PW'($urandom);
            end
            pndng = req;

            s = c % 4;
            if (e_gset[s]) m_grant = e_grant[s];
            if (e_dset[s]) m_dpush = e_dval[s];
            n_cmp++;
            if (pop !== e_pop[s] || push !== e_push[s] || drop_pls !== e_drop[s] || busy !== e_busy[s]) begin
                n_err++;
                $display("FAIL rnd_ctrl c=%0d: got pop=%b push=%b drop=%b busy=%b, expected pop=%b push=%b drop=%b busy=%b",
                         c, pop, push, drop_pls, busy, e_pop[s], e_push[s], e_drop[s], e_busy[s]);
            end
            n_cmp++;
            if (grant_id !== m_grant || D_push !== {DRV{m_dpush}}) begin
                n_err++;
                $display("FAIL rnd_data c=%0d: got gid=%0d D_push=%h, expected gid=%0d word=%h", c, grant_id, D_push, m_grant, m_dpush);
            end
            e_pop[s] = '0; e_push[s] = '0; e_drop[s] = 0; e_busy[s] = 0; e_gset[s] = 0; e_dset[s] = 0;

            if (c >= idle_at && req != '0) begin
                g = -1;
                for (int k = 1; k <= DRV; k++)
                    if (g < 0 && req[(m_last + k) % DRV]) g = (m_last + k) % DRV;
                w = fifo[g][0];
                d = w[PW-1 -: 8];
                s1 = (c + 1) % 4;
                s2 = (c + 2) % 4;
                e_pop[s1] = 4'b0001 << g; e_busy[s1] = 1; e_gset[s1] = 1; e_grant[s1] = 2'(g);
                e_busy[s2] = 1;
                if (d == 8'hFF) begin
                    e_push[s2] = 4'b1111 & ~(4'b0001 << g); e_dset[s2] = 1; e_dval[s2] = w;
                end else if (d < DRV) begin
                    e_push[s2] = 4'b0001 << d; e_dset[s2] = 1; e_dval[s2] = w;
                end else begin
                    e_drop[s2] = 1;
                end
                idle_at = c + 3;
                m_last = g;
            end
            prev_pop = pop;
            tick();
        end
        pndng = '0;
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_invalid();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
